// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester bus and RAM command bus shared between ram_arbiter and its environment.
interface ram_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic [2:0]          req;
   logic [2:0]          lock;
   logic [2:0]          we;
   logic [3*ADDR_W-1:0] addr_flat;
   logic [3*DATA_W-1:0] wdata_flat;
   logic [2:0]          gnt;
   logic [2:0]          ack;
   logic [DATA_W-1:0]   rdata;
   logic                busy;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_write_data;
   logic                mem_write;
   logic [DATA_W-1:0]   mem_read_data;
   modport slave (
      input  req, lock, we, addr_flat, wdata_flat, mem_read_data,
      output gnt, ack, rdata, busy, mem_addr, mem_write_data, mem_write
   );
   modport master (
      output req, lock, we, addr_flat, wdata_flat, mem_read_data,
      input  gnt, ack, rdata, busy, mem_addr, mem_write_data, mem_write
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: three-requester single-port RAM arbiter with burst lock and forced release after MAX_HOLD.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module ram_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 16,
   parameter int MAX_HOLD = 8
) (
   input  logic         clock,
   input  logic         reset,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
   state_t            state_q, state_d;
   logic [1:0]        own_q, own_d, win, sel;
   logic [3:0]        hold_q, hold_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
   logic              mem_write_q, mem_write_d, relock;
   logic [2:0]        gnt;
   logic [ADDR_W-1:0] addr_a [3];
   logic [DATA_W-1:0] wdata_a [3];
   for (genvar i = 0; i < 3; i++) begin : g_unpack
      assign addr_a[i]  = bus.addr_flat[i*ADDR_W +: ADDR_W];
      assign wdata_a[i] = bus.wdata_flat[i*DATA_W +: DATA_W];
   end
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d, c1, c2;
   assign c1    = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
   assign c2    = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
   assign win   = bus.req[c1] ? c1 : bus.req[c2] ? c2 : ptr_q;
   assign ptr_d = (state_q == IDLE && |bus.req) ? win : ptr_q;
   always_ff @(posedge clock or posedge reset)
      if (reset) ptr_q <= 2'd2;
      else       ptr_q <= ptr_d;
`else
   assign win = bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : 2'd2;
`endif
   assign sel    = (state_q == IDLE) ? win : own_q;
   assign relock = bus.req[own_q] & bus.lock[own_q] & (hold_q < HOLD_MAX);
   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      hold_d      = hold_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_write_d = 1'b0;
      rdata_d     = rdata_q;
      case (state_q)
         IDLE: if (|bus.req) begin
            state_d = ACCESS;
            own_d   = win;
            hold_d  = 4'd1;
         end
         ACCESS: state_d = RESP;
         RESP: begin
            rdata_d = bus.mem_read_data;
            state_d = relock ? ACCESS : IDLE;
            hold_d  = relock ? hold_q + 4'd1 : 4'd0;
         end
         default: state_d = IDLE;
      endcase
      // every entry into ACCESS latches a fresh command so later input changes cannot disturb it
      if (state_d == ACCESS && state_q != ACCESS) begin
         mem_addr_d  = addr_a[sel];
         mem_wdata_d = wdata_a[sel];
         mem_write_d = bus.we[sel];
      end
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         own_q       <= 2'd0;
         hold_q      <= 4'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         hold_q      <= hold_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_write_q <= mem_write_d;
         rdata_q     <= rdata_d;
      end
   assign gnt                = (state_q == IDLE) ? 3'b000 : 3'b001 << own_q;
   assign bus.gnt            = gnt;
   assign bus.ack            = (state_q == RESP) ? gnt : 3'b000;
   assign bus.rdata          = (state_q == RESP) ? bus.mem_read_data : rdata_q;
   assign bus.busy           = state_q != IDLE;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_write_data = mem_wdata_q;
   assign bus.mem_write      = mem_write_q;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 5, RAM address width.
REQ-002 Parameter: DATA_W, 16, RAM data width.
REQ-003 Parameter: MAX_HOLD, 8, max consecutive locked accesses per owner before forced release (1..15).
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: req  input  3  per-requester access request (bit 0 loader, bit 1 cpu, bit 2 debug).
REQ-007 Port: lock  input  3  per-requester burst lock; honoured only while that requester owns the RAM.
REQ-008 Port: we  input  3  per-requester write enable (1 write, 0 read).
REQ-009 Port: addr_flat  input  3*ADDR_W  requester addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port: wdata_flat  input  3*DATA_W  requester write data, same packing.
REQ-011 Port: gnt  output  3  one-hot owner indicator, zero when no owner.
REQ-012 Port: ack  output  3  one-cycle completion pulse to the owner.
REQ-013 Port: rdata  output  DATA_W  read data, valid in the ack cycle.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: mem_addr / mem_write_data / mem_write  output  ADDR_W / DATA_W / 1  registered RAM command.
REQ-016 Port: mem_read_data  input  DATA_W  RAM read data, valid one cycle after address is presented.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-018 IDLE: if req!=0, select winner, capture its addr/wdata/we into mem_* registers, set gnt, go ACCESS; else stay.
REQ-019 ACCESS: mem_write SHALL equal captured we for exactly this one cycle; next state RESP.
REQ-020 RESP: ack[owner]=1 for one cycle; rdata SHALL equal mem_read_data (reads) and hold its value until the next ack; mem_write=0.
REQ-021 RESP exit: if req[owner]&lock[owner] and hold_cnt<MAX_HOLD, recapture owner's command and go ACCESS (gnt unchanged, hold_cnt+1); else clear gnt, hold_cnt=0, go IDLE.
REQ-022 Latency: req sampled high in IDLE at edge N -> gnt at N+1, ack at N+2; locked burst yields one ack every 2 cycles.
REQ-023 hold_cnt SHALL count accesses in the current ownership, starting at 1 on grant; with MAX_HOLD=1 lock has no effect.
REQ-024 Command is captured at grant, so deasserting req or changing addr during ACCESS/RESP SHALL NOT alter the in-flight access; ack is still pulsed.
REQ-025 Requests from non-owners during ACCESS/RESP SHALL be held off (no gnt, no ack) and arbitrated at the next IDLE.
REQ-026 gnt SHALL never have more than one bit set; ack SHALL only appear on the gnt bit.
REQ-027 rdata for write accesses SHALL be unspecified-but-stable (whatever mem_read_data returns); requesters ignore it.

Reset
REQ-028 Reset SHALL asynchronously force IDLE, gnt=0, ack=0, busy=0, mem_write=0, mem_addr=0, mem_write_data=0, rdata=0, hold_cnt=0, last-grant pointer=2.
REQ-029 Reset during ACCESS SHALL suppress the write immediately; no ack for the aborted access is ever issued.
REQ-030 First arbitration after reset SHALL begin at requester 0.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: winner is first requesting index after last-grant pointer (cyclic 0->1->2->0); pointer updates on each new grant.
REQ-032 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority 0>1>2; pointer logic absent; all other behaviour identical.

Verification
REQ-033 Single read: preload RAM[5]=16'hBEEF, req=3'b010, we=0, cpu addr=5 -> gnt=3'b010 at N+1, ack=3'b010 and rdata=16'hBEEF at N+2, busy low at N+3.
REQ-034 Write then read: loader writes 16'h1234 to addr 31, then reads addr 31 -> mem_write high exactly one cycle, read returns 16'h1234.
REQ-035 Contention: req=3'b111 held constantly, no lock -> RR build: grant order 0,1,2,0,...; fixed build: 0,0,0,...
REQ-036 Locked burst: loader req+lock for 12 accesses, cpu req high, MAX_HOLD=8 -> 8 loader acks every 2 cycles, then gnt leaves loader, cpu served, loader resumes later.
REQ-037 Reset mid-write: assert reset while in ACCESS with we=1 to addr 3 (RAM[3]=0) -> mem_write drops immediately, RAM[3] stays 0, no ack, first post-reset grant to requester 0 when req=3'b111.
REQ-038 Input change in flight: drop req and change addr to 7 during ACCESS of read from addr 2 -> ack still issued, rdata=RAM[2].
